// File: rtl/vga_pkg.sv
// Shared VGA definitions: timing presets, per-axis region encoding, the
// control bundle that travels down the realignment delay line, and a colour packer.
package vga_pkg;

  typedef enum logic [1:0] {RGN_SYNC, RGN_BP, RGN_ACT, RGN_FP} region_e;

  typedef struct packed {
    int h_sync; int h_bp; int h_act; int h_fp;
    int v_sync; int v_bp; int v_act; int v_fp;
  } vga_timing_t;

  localparam vga_timing_t VGA_640x480_60 = '{96, 48, 640, 16, 2, 33, 480, 10};
  localparam vga_timing_t VGA_800x600_60 = '{128, 88, 800, 40, 4, 23, 600, 1};

  // Raw (polarity-free) controls; sync fields are 1 while the pulse is asserted.
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic ls;
    logic fs;
  } vid_ctl_t;

  // Stage-0 decode while the counters sit at (0,0): both syncs asserted, nothing active.
  localparam vid_ctl_t CTL_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0, ls: 1'b0, fs: 1'b0};

  // Packs the low cw bits of each channel as {R,G,B}, right-aligned.
  function automatic logic [23:0] rgb_pack(input logic [7:0] r, input logic [7:0] g,
                                           input logic [7:0] b, input int cw);
    logic [23:0] p;
    p = '0;
    for (int k = 0; k < cw; k++) begin
      p[2*cw+k] = r[k];
      p[cw+k]   = g[k];
      p[k]      = b[k];
    end
    return p;
  endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// One raster axis: 0-based position counter with sync/porch/active region decode.
module vga_axis_cnt
  import vga_pkg::*;
#(
  parameter int SYNC = 96,
  parameter int BP   = 48,
  parameter int ACT  = 640,
  parameter int FP   = 16,
  parameter int AW   = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [AW-1:0] cnt,
  output logic          wrap,
  output logic          in_sync,
  output logic          in_act,
  output logic [AW-1:0] pos
);
  localparam int            TOT    = SYNC + BP + ACT + FP;
  localparam logic [AW-1:0] LAST   = AW'(TOT - 1);
  localparam logic [AW-1:0] BP_LO  = AW'(SYNC);
  localparam logic [AW-1:0] ACT_LO = AW'(SYNC + BP);
  localparam logic [AW-1:0] FP_LO  = AW'(SYNC + BP + ACT);

  region_e region;

  always_ff @(posedge clk or negedge rst)
    if (!rst)    cnt <= '0;
    else if (en) cnt <= wrap ? '0 : cnt + AW'(1);

  assign wrap = (cnt == LAST);

  always_comb begin
    region = RGN_FP;
    if (cnt < BP_LO)       region = RGN_SYNC;
    else if (cnt < ACT_LO) region = RGN_BP;
    else if (cnt < FP_LO)  region = RGN_ACT;
  end

  assign in_sync = (region == RGN_SYNC);
  assign in_act  = (region == RGN_ACT);
  assign pos     = in_act ? cnt - ACT_LO : '0;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: issues frame-buffer coordinates RD_LAT ticks
// early and realigns the returned colour with delayed sync/blank at the pins.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_SYNC  = 96,
  parameter int   H_BP    = 48,
  parameter int   H_ACT   = 640,
  parameter int   H_FP    = 16,
  parameter int   V_SYNC  = 2,
  parameter int   V_BP    = 33,
  parameter int   V_ACT   = 480,
  parameter int   V_FP    = 10,
  parameter logic HS_POL  = 1'b0,
  parameter logic VS_POL  = 1'b0,
  parameter int   CLK_DIV = 1,
  parameter int   RD_LAT  = 1,
  parameter int   CW      = 4,
  parameter int   AW      = 10
) (
  input  logic          clk,
  input  logic          rst,
  output logic          pix_tick,
  output logic          req_valid,
  output logic [AW-1:0] req_x,
  output logic [AW-1:0] req_y,
  input  logic [3*CW-1:0] pix_data,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] vga_r,
  output logic [CW-1:0] vga_g,
  output logic [CW-1:0] vga_b,
  output logic          frame_start,
  output logic          line_start,
  output logic [15:0]   frame_cnt
);
  localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  if (H_TOT > (1 << AW) - 1 || V_TOT > (1 << AW) - 1) begin : g_bad_tot
    $error("vga_timing_gen: H_TOT=%0d / V_TOT=%0d do not fit in AW=%0d bits", H_TOT, V_TOT, AW);
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be >= 1 (got %0d)", CLK_DIV);
  end
  if (RD_LAT < 0 || RD_LAT > 7) begin : g_bad_lat
    $error("vga_timing_gen: RD_LAT must be 0..7 (got %0d)", RD_LAT);
  end

  // Pixel tick divider; with CLK_DIV=1 div_cnt is stuck at 0 so the tick is held high.
  logic [DW-1:0] div_cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst)          div_cnt <= '0;
    else if (pix_tick) div_cnt <= '0;
    else               div_cnt <= div_cnt + DW'(1);

  assign pix_tick = (div_cnt == DIV_LAST);

  logic [AW-1:0] h_cnt, v_cnt, h_pos, v_pos;
  logic          h_wrap, v_wrap, h_in_sync, v_in_sync, h_act, v_act;

  vga_axis_cnt #(.SYNC(H_SYNC), .BP(H_BP), .ACT(H_ACT), .FP(H_FP), .AW(AW)) u_h_cnt (
    .clk(clk), .rst(rst), .en(pix_tick), .cnt(h_cnt), .wrap(h_wrap),
    .in_sync(h_in_sync), .in_act(h_act), .pos(h_pos)
  );

  vga_axis_cnt #(.SYNC(V_SYNC), .BP(V_BP), .ACT(V_ACT), .FP(V_FP), .AW(AW)) u_v_cnt (
    .clk(clk), .rst(rst), .en(pix_tick & h_wrap), .cnt(v_cnt), .wrap(v_wrap),
    .in_sync(v_in_sync), .in_act(v_act), .pos(v_pos)
  );

  // Raw counters are only needed inside the axis blocks.
  logic unused_cnt;
  assign unused_cnt = ^{h_cnt, v_cnt};

  // Counts at the counter wrap, not when the last pixel reaches the pins.
  always_ff @(posedge clk or negedge rst)
    if (!rst)                             frame_cnt <= '0;
    else if (pix_tick & h_wrap & v_wrap)  frame_cnt <= frame_cnt + 16'd1;

  assign req_valid = h_act & v_act;
  assign req_x     = req_valid ? h_pos : '0;
  assign req_y     = req_valid ? v_pos : '0;

  vid_ctl_t ctl_s0, ctl_d;
  always_comb begin
    ctl_s0    = CTL_IDLE;
    ctl_s0.hs = h_in_sync;
    ctl_s0.vs = v_in_sync;
    ctl_s0.de = req_valid;
    ctl_s0.ls = req_valid & (req_x == '0);
    ctl_s0.fs = req_valid & (req_x == '0) & (req_y == '0);
  end

  // Controls wait RD_LAT ticks for the frame buffer; reset loads the (0,0) decode.
  if (RD_LAT == 0) begin : g_no_dly
    assign ctl_d = ctl_s0;
  end else begin : g_dly
    vid_ctl_t [RD_LAT-1:0] ctl_pipe;
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        for (int i = 0; i < RD_LAT; i++) ctl_pipe[i] <= CTL_IDLE;
      end else if (pix_tick) begin
        ctl_pipe[0] <= ctl_s0;
        for (int i = 1; i < RD_LAT; i++) ctl_pipe[i] <= ctl_pipe[i-1];
      end
    assign ctl_d = ctl_pipe[RD_LAT-1];
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      hsync                 <= HS_POL;
      vsync                 <= VS_POL;
      de                    <= 1'b0;
      line_start            <= 1'b0;
      frame_start           <= 1'b0;
      {vga_r, vga_g, vga_b} <= '0;
    end else if (pix_tick) begin
      hsync                 <= ctl_d.hs ? HS_POL : ~HS_POL;
      vsync                 <= ctl_d.vs ? VS_POL : ~VS_POL;
      de                    <= ctl_d.de;
      line_start            <= ctl_d.ls;
      frame_start           <= ctl_d.fs;
      {vga_r, vga_g, vga_b} <= pix_data & {3*CW{ctl_d.de}};
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Three small-raster instances (base, CLK_DIV=3, RD_LAT=3 with high hsync) checked
// through a scoreboard against an arithmetic raster model and a frame-buffer model.
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int HT = 10, VT = 6, FT = HT * VT;
  localparam int DIV  [3] = '{1, 3, 1};
  localparam int LAT  [3] = '{1, 1, 3};
  localparam int HPOL [3] = '{0, 0, 1};

  typedef struct packed {
    logic        tick, rv;
    logic [9:0]  rx, ry;
    logic        hs, vs, de, fs, ls;
    logic [11:0] rgb;
    logic [15:0] fc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n     [3] = '{default: 1'b0};
  logic [11:0] pix_data  [3] = '{default: '0};
  logic        pix_tick  [3], req_valid [3], hsync [3], vsync [3], de [3];
  logic        frame_start [3], line_start [3];
  logic [9:0]  req_x [3], req_y [3];
  logic [3:0]  vga_r [3], vga_g [3], vga_b [3];
  logic [15:0] frame_cnt [3];

  int   n [3];
  logic [11:0] fbq [3][8] = '{default: '0};
  exp_t q [3][$];
  int   checks = 0, errors = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 3; i++) begin : g_dut
    vga_timing_gen #(
      .H_SYNC(2), .H_BP(2), .H_ACT(4), .H_FP(2), .V_SYNC(1), .V_BP(1), .V_ACT(3), .V_FP(1),
      .HS_POL(1'(HPOL[i])), .VS_POL(1'b0), .CLK_DIV(DIV[i]), .RD_LAT(LAT[i]), .CW(4), .AW(10)
    ) u_dut (
      .clk(clk), .rst(rst_n[i]), .pix_tick(pix_tick[i]), .req_valid(req_valid[i]),
      .req_x(req_x[i]), .req_y(req_y[i]), .pix_data(pix_data[i]), .hsync(hsync[i]),
      .vsync(vsync[i]), .de(de[i]), .vga_r(vga_r[i]), .vga_g(vga_g[i]), .vga_b(vga_b[i]),
      .frame_start(frame_start[i]), .line_start(line_start[i]), .frame_cnt(frame_cnt[i])
    );
  end

  task automatic chk(input string nm, input int id, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t got=%0h expected=%0h", nm, id, $time, got, exp);
    end
  endtask

  // Expected pins/requests after n clk edges out of reset, from the raster rules alone.
  function automatic exp_t model(input bit rst, input int nclk, input int div, input int lat, input bit hpol);
    exp_t e;
    int t, src, h, v;
    e    = '0;
    e.hs = hpol;
    e.vs = 1'b0;
    if (!rst) begin
      e.tick = (div == 1);
      return e;
    end
    t      = nclk / div;
    e.tick = (nclk % div) == div - 1;
    e.fc   = 16'(t / FT);
    h = t % HT;
    v = (t / HT) % VT;
    if (h >= 4 && h < 8 && v >= 2 && v < 5) begin
      e.rv = 1'b1;
      e.rx = 10'(h - 4);
      e.ry = 10'(v - 2);
    end
    src = t - 1 - lat;
    if (src >= 0) begin
      h = src % HT;
      v = (src / HT) % VT;
      e.hs = (h < 2) ? hpol : !hpol;
      e.vs = (v < 1) ? 1'b0 : 1'b1;
      if (h >= 4 && h < 8 && v >= 2 && v < 5) begin
        e.de  = 1'b1;
        e.rgb = {4'(h - 4), 4'(v - 2), 4'hA};
        e.ls  = (h == 4);
        e.fs  = (h == 4) && (v == 2);
      end
    end
    return e;
  endfunction

  function automatic exp_t actual(input int i);
    exp_t a;
    a = '{tick: pix_tick[i], rv: req_valid[i], rx: req_x[i], ry: req_y[i], hs: hsync[i],
          vs: vsync[i], de: de[i], fs: frame_start[i], ls: line_start[i],
          rgb: {vga_r[i], vga_g[i], vga_b[i]}, fc: frame_cnt[i]};
    return a;
  endfunction

  always @(posedge clk)
    for (int i = 0; i < 3; i++) n[i] = rst_n[i] ? n[i] + 1 : 0;

  // Frame buffer answering each tick's request LAT ticks later, plus scoreboard push.
  always begin
    logic [11:0] d;
    @(negedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      if (pix_tick[i]) begin
        if (req_valid[i]) d = 12'(rgb_pack(8'(req_x[i]), 8'(req_y[i]), 8'hA, 4));
        else              d = (i == 2) ? 12'hFFF : 12'($urandom);
        if (LAT[i] == 0) pix_data[i] = d;
        else begin
          pix_data[i] = fbq[i][LAT[i]-1];
          for (int j = 7; j > 0; j--) fbq[i][j] = fbq[i][j-1];
          fbq[i][0] = d;
        end
      end
      q[i].push_back(model(rst_n[i], n[i], DIV[i], LAT[i], HPOL[i] != 0));
    end
  end

  always begin
    exp_t e, a;
    @(negedge clk); #2;
    for (int i = 0; i < 3; i++) begin
      if (q[i].size() == 0) chk("sb_empty", i, 64'd1, 64'd0);
      else begin
        e = q[i].pop_front();
        a = actual(i);
        chk("tick_req",  i, {a.tick, a.rv, a.rx, a.ry}, {e.tick, e.rv, e.rx, e.ry});
        chk("sync_de",   i, {a.hs, a.vs, a.de}, {e.hs, e.vs, e.de});
        chk("rgb",       i, a.rgb, e.rgb);
        chk("pulses",    i, {a.fs, a.ls}, {e.fs, e.ls});
        chk("frame_cnt", i, a.fc, e.fc);
      end
    end
  end

  initial begin
    fork
      begin : seq_a
        int vs_lo, de_n, ls_n, fs_n;
        vs_lo = 0; de_n = 0; ls_n = 0; fs_n = 0;
        repeat (5) @(negedge clk);
        rst_n[0] = 1'b1;
        for (int j = 1; j <= 181; j++) begin
          @(negedge clk); #2;
          if (j >= 2) begin
            vs_lo += int'(vsync[0] == 1'b0);
            de_n  += int'(de[0]);
            ls_n  += int'(line_start[0]);
            fs_n  += int'(frame_start[0]);
          end
          if (j == 180) chk("a_frame_cnt_after_3_frames", 0, frame_cnt[0], 16'd3);
        end
        chk("a_vsync_low_ticks", 0, vs_lo, 30);
        chk("a_de_ticks",        0, de_n, 36);
        chk("a_line_starts",     0, ls_n, 9);
        chk("a_frame_starts",    0, fs_n, 3);
        // Lands on h_cnt=5, v_cnt=2.
        repeat (24) @(negedge clk);
        rst_n[0] = 1'b0;
        @(negedge clk);
        rst_n[0] = 1'b1;
        repeat (3) begin
          repeat ($urandom_range(150, 40)) @(negedge clk);
          rst_n[0] = 1'b0;
          repeat ($urandom_range(3, 1)) @(negedge clk);
          rst_n[0] = 1'b1;
        end
        repeat (200) @(negedge clk);
      end
      begin : seq_b
        int ticks;
        ticks = 0;
        repeat (5) @(negedge clk);
        rst_n[1] = 1'b1;
        for (int j = 1; j <= 620; j++) begin
          @(negedge clk); #2;
          if (j <= 180) ticks += int'(pix_tick[1]);
          if (j == 179) chk("b_frame_cnt_before_180clk", 1, frame_cnt[1], 16'd0);
          if (j == 180) chk("b_frame_cnt_at_180clk", 1, frame_cnt[1], 16'd1);
        end
        chk("b_ticks_in_180clk", 1, ticks, 60);
      end
      begin : seq_c
        bit seen;
        seen = 1'b0;
        repeat (5) @(negedge clk);
        rst_n[2] = 1'b1;
        repeat (400) begin
          @(negedge clk); #2;
          if (de[2] && !seen) begin
            chk("c_first_de_x", 2, vga_r[2], 4'd0);
            seen = 1'b1;
          end
        end
        chk("c_de_seen", 2, 64'(seen), 64'd1);
      end
    join
    @(negedge clk); #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
